// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the multi-channel SPI ADC sequencer.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_PAUSE,
    S_HOLD
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_MSB   = 13;
  localparam int MAX_CH     = 8;

  // Next enabled channel strictly above i, wrapping to the lowest enabled one.
  // With i = MAX_CH-1 this returns the lowest enabled channel.
  function automatic logic [2:0] next_ch(input logic [MAX_CH-1:0] mask, input logic [2:0] i);
    logic [2:0] c;
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      c = i + 3'(k);
      if (!found && mask[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_frame.sv
// One 16-bit SPI mode-3 frame: csn low, 16 SCLK periods, csn high.
// done_o pulses on the edge that raises csn; data_o holds the last DATA_W bits.
module adc_spi_frame
  import adc_scan_pkg::*;
#(
  parameter int HALF   = 2,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_i,
  input  logic [2:0]        addr_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  output logic              spi_csn_o,
  input  logic              spi_miso_i
);

  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

  logic                  act_q, tail_q, sclk_q, mosi_q, csn_q;
  logic [HW-1:0]         half_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-1:0] word_q;
  logic [DATA_W-1:0]     sh_q;
  logic                  tick;

  assign tick       = act_q && (half_q == HW'(HALF - 1));
  assign done_o     = tick && tail_q;
  assign data_o     = sh_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_csn_o  = csn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      tail_q <= 1'b0;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      csn_q  <= 1'b1;
      half_q <= '0;
      bit_q  <= '0;
      word_q <= '0;
      sh_q   <= '0;
    end else if (go_i && !act_q) begin
      act_q  <= 1'b1;
      csn_q  <= 1'b0;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      half_q <= '0;
      bit_q  <= '0;
      tail_q <= 1'b0;
      word_q <= '0;
      word_q[ADDR_MSB -: 3] <= addr_i;
    end else if (act_q) begin
      half_q <= tick ? '0 : half_q + 1'b1;
      if (tick) begin
        // Tail is the extra half period between the 16th rising edge and csn rise.
        if (tail_q) begin
          csn_q  <= 1'b1;
          act_q  <= 1'b0;
          tail_q <= 1'b0;
          mosi_q <= 1'b0;
        end else if (sclk_q) begin
          sclk_q <= 1'b0;
          mosi_q <= word_q[4'd15 - bit_q];
        end else begin
          sclk_q <= 1'b1;
          sh_q   <= {sh_q[DATA_W-2:0], spi_miso_i};
          if (bit_q == 4'd15) begin
            tail_q <= 1'b1;
            bit_q  <= '0;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Masked channel scanner for a pipelined-address SPI ADC with a valid/ready
// result stream; single-shot or continuous scanning.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int SCLK_HZ     = 5000000,
  parameter int CH_NUM      = 8,
  parameter int DATA_W      = 12,
  parameter int CYCLE_PAUSE = 10,
  localparam int CH_W       = $clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CH_NUM-1:0] ch_mask,
  output logic              busy,
  output logic              scan_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_chan,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_csn,
  input  logic              spi_miso
);

  localparam int HALF = CLK_HZ / (2 * SCLK_HZ);
  localparam int PW   = (CYCLE_PAUSE > 1) ? $clog2(CYCLE_PAUSE) : 1;

  if (HALF < 1 || (CLK_HZ % (2 * SCLK_HZ)) != 0) begin : g_bad_half
    $error("adc_scan_ctrl: CLK_HZ/(2*SCLK_HZ) must be an integer >= 1");
  end
  if (CH_NUM < 2 || CH_NUM > MAX_CH) begin : g_bad_ch
    $error("adc_scan_ctrl: CH_NUM must be 2..8");
  end
  if (DATA_W < 2 || DATA_W > FRAME_BITS) begin : g_bad_dw
    $error("adc_scan_ctrl: DATA_W must be <= 16");
  end
  if (CYCLE_PAUSE < 1) begin : g_bad_pause
    $error("adc_scan_ctrl: CYCLE_PAUSE must be >= 1");
  end

  state_e            state_q, state_d;
  logic [MAX_CH-1:0] mask_q, mask_in;
  logic              mode_q, stop_q, end_q, busy_q, ret_vld_q;
  logic [2:0]        send_q, ret_q;
  logic              ov_q, olast_q;
  logic [DATA_W-1:0] od_q;
  logic [2:0]        oc_q;
  logic [PW-1:0]     pcnt_q;

  logic              go, start_ok, acc, pend, pause_end, ret_last, fdone;
  logic [2:0]        go_addr, first_ch;
  logic [DATA_W-1:0] fdata;

  assign mask_in   = MAX_CH'(ch_mask);
  assign start_ok  = start && (ch_mask != '0);
  assign acc       = ov_q && m_ready;
  assign pend      = ov_q && !m_ready;
  assign pause_end = (state_q == S_PAUSE) && (pcnt_q == PW'(CYCLE_PAUSE - 1));
  assign first_ch  = next_ch(mask_q, 3'd7);
  assign ret_last  = (next_ch(mask_q, ret_q) == first_ch);

  assign busy      = busy_q;
  assign scan_done = acc && olast_q;
  assign m_valid   = ov_q;
  assign m_data    = od_q;
  assign m_chan    = oc_q[CH_W-1:0];

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    go_addr = next_ch(mask_q, send_q);
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FRAME;
          go      = 1'b1;
          go_addr = next_ch(mask_in, 3'd7);
        end
      end
      S_FRAME: begin
        if (fdone) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_end) begin
          if (pend) begin
            state_d = S_HOLD;
          end else if (end_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FRAME;
            go      = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (acc) begin
          if (end_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FRAME;
            go      = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      stop_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      ret_vld_q <= 1'b0;
      send_q    <= '0;
      ret_q     <= '0;
      ov_q      <= 1'b0;
      olast_q   <= 1'b0;
      od_q      <= '0;
      oc_q      <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= (state_q == S_PAUSE && !pause_end) ? pcnt_q + 1'b1 : '0;

      if (state_q == S_IDLE && start_ok) begin
        mode_q    <= mode;
        mask_q    <= mask_in;
        stop_q    <= 1'b0;
        end_q     <= 1'b0;
        busy_q    <= 1'b1;
        ret_vld_q <= 1'b0;
        send_q    <= go_addr;
      end else if (go) begin
        // Address pipeline: this frame returns what the previous one addressed.
        ret_q     <= send_q;
        ret_vld_q <= 1'b1;
        send_q    <= go_addr;
      end

      if (busy_q && stop) stop_q <= 1'b1;

      if (acc) begin
        ov_q <= 1'b0;
        if (olast_q && end_q) busy_q <= 1'b0;
      end

      if (state_q == S_FRAME && fdone) begin
        if (ret_vld_q) begin
          ov_q    <= 1'b1;
          od_q    <= fdata;
          oc_q    <= ret_q;
          olast_q <= ret_last;
        end
        // Decided when the final frame ends; a later stop belongs to the next scan.
        end_q <= ret_vld_q && ret_last && (!mode_q || stop_q || stop);
      end
    end
  end

  adc_spi_frame #(
    .HALF  (HALF),
    .DATA_W(DATA_W)
  ) u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_i      (go),
    .addr_i    (go_addr),
    .done_o    (fdone),
    .data_o    (fdata),
    .spi_sclk_o(spi_sclk),
    .spi_mosi_o(spi_mosi),
    .spi_csn_o (spi_csn),
    .spi_miso_i(spi_miso)
  );

endmodule
